// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 16-bit CPU datapath.
// Steps each instruction through FETCH, DECODE, optional EXT, OPRD, EXEC and WB.
// It issues one-cycle datapath strobes and counts retired instructions.
// Optional feature: define JUMP_EN to enable JMP/JEQ handling in WB. When it is
// undefined, pc_load is tied low.
//
// state  | meaning
// IDLE   | waiting for en
// FETCH  | ROM read of the word addressed by PC
// DECODE | latch instruction, advance PC
// EXT    | consume the extension word (RAM read in direct mode)
// OPRD   | load both ALU operands
// EXEC   | ALU busy for EXEC_CYCLES cycles
// WB     | register writeback / jump, retire
// FAULT  | illegal operation type, sticky until reset
module cpu_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter logic [3:0]  CMP_OPCODE  = 4'b1111,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       ins_byte,
  input  logic [1:0]       ins_mode,
  input  logic [1:0]       ins_ot,
  input  logic [3:0]       ins_opcode,
  input  logic             flag_eq,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             ins_load,
  output logic             op1_load,
  output logic             op2_load,
  output logic             ram_rd,
  output logic             reg_load,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXT    = 3'd3,
    S_OPRD   = 3'd4,
    S_EXEC   = 3'd5,
    S_WB     = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [3:0]       EXEC_LAST = 4'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] RET_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_q, state_d;
  logic [3:0] exec_cnt;
  logic       two_word, is_cmp, is_jump, jump_taken;
  logic       pc_load_d, pc_inc_d, ins_load_d, op1_load_d, op2_load_d;
  logic       ram_rd_d, reg_load_d, busy_d, fault_d;

  assign state    = state_q;
  assign two_word = (ins_byte == 2'b10);
  assign is_cmp   = (ins_ot == 2'b01) && (ins_opcode == CMP_OPCODE);

`ifdef JUMP_EN
  assign is_jump    = (ins_ot == 2'b00) && two_word &&
                      ((ins_opcode == 4'b1110) || (ins_opcode == 4'b1101));
  assign jump_taken = (ins_ot == 2'b00) && two_word &&
                      ((ins_opcode == 4'b1110) || ((ins_opcode == 4'b1101) && flag_eq));
`else
  logic unused_flag_eq;
  assign unused_flag_eq = flag_eq;
  assign is_jump        = 1'b0;
  assign jump_taken     = 1'b0;
`endif

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // EXEC down-counter: reloads outside EXEC, terminal count at zero ends EXEC
  always_ff @(posedge clk) begin
    if (!rst_n)                 exec_cnt <= EXEC_LAST;
    else if (state_q != S_EXEC) exec_cnt <= EXEC_LAST;
    else if (exec_cnt != 4'd0)  exec_cnt <= exec_cnt - 4'd1;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (en) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (ins_ot == 2'b11) state_d = S_FAULT;
        else if (two_word)   state_d = S_EXT;
        else                 state_d = S_OPRD;
      end
      S_EXT:    state_d = S_OPRD;
      S_OPRD:   state_d = S_EXEC;
      S_EXEC:   if (exec_cnt == 4'd0) state_d = S_WB;
      S_WB:     state_d = en ? S_FETCH : S_IDLE;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every strobe leaves a flop
  always_comb begin
    pc_load_d  = 1'b0;
    pc_inc_d   = 1'b0;
    ins_load_d = 1'b0;
    op1_load_d = 1'b0;
    op2_load_d = 1'b0;
    ram_rd_d   = 1'b0;
    reg_load_d = 1'b0;
    busy_d     = (state_d != S_IDLE) && (state_d != S_FAULT);
    fault_d    = (state_d == S_FAULT);
    case (state_d)
      S_DECODE: begin
        ins_load_d = 1'b1;
        pc_inc_d   = 1'b1;
      end
      S_EXT: begin
        pc_inc_d = 1'b1;
        ram_rd_d = (ins_mode == 2'b10);
      end
      S_OPRD: begin
        op1_load_d = 1'b1;
        op2_load_d = 1'b1;
      end
      S_WB: begin
        reg_load_d = !is_cmp && !is_jump;
        pc_load_d  = jump_taken;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_load  <= 1'b0;
      pc_inc   <= 1'b0;
      ins_load <= 1'b0;
      op1_load <= 1'b0;
      op2_load <= 1'b0;
      ram_rd   <= 1'b0;
      reg_load <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      pc_load  <= pc_load_d;
      pc_inc   <= pc_inc_d;
      ins_load <= ins_load_d;
      op1_load <= op1_load_d;
      op2_load <= op2_load_d;
      ram_rd   <= ram_rd_d;
      reg_load <= reg_load_d;
      busy     <= busy_d;
      fault    <= fault_d;
    end
  end

  // Retired-instruction counter, bumped as each WB cycle completes
  always_ff @(posedge clk) begin
    if (!rst_n)              retired <= '0;
    else if (state_q == S_WB) retired <= retired + RET_ONE;
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer.
// Expected per-cycle output vectors are queued as each instruction is issued
// and popped one per cycle. A small counter width exercises retired wrap.
// Define JUMP_EN to exercise the JMP/JEQ writeback path.
module tb_cpu_sequencer;

  localparam int unsigned EXEC_N = 3;
  localparam int unsigned CW     = 4;
  localparam logic [3:0]  CMP    = 4'b1111;

  logic          clk = 1'b0;
  logic          rst_n, en, flag_eq;
  logic [1:0]    ins_byte, ins_mode, ins_ot;
  logic [3:0]    ins_opcode;
  logic          pc_load, pc_inc, ins_load, op1_load, op2_load, ram_rd, reg_load, busy, fault;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  int total = 0;
  int bad   = 0;
  logic [11:0]   exp_q[$];
  logic [CW-1:0] exp_ret = '0;
  int            pc_inc_seen;

  cpu_sequencer #(.EXEC_CYCLES(EXEC_N), .CMP_OPCODE(CMP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ins_byte(ins_byte), .ins_mode(ins_mode), .ins_ot(ins_ot), .ins_opcode(ins_opcode),
    .flag_eq(flag_eq),
    .pc_load(pc_load), .pc_inc(pc_inc), .ins_load(ins_load),
    .op1_load(op1_load), .op2_load(op2_load), .ram_rd(ram_rd), .reg_load(reg_load),
    .busy(busy), .fault(fault), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {state, pc_load, pc_inc, ins_load, op1, op2, ram_rd, reg_load, busy, fault}
  function automatic logic [11:0] mk(input logic [2:0] st, input logic pl, input logic pi,
                                     input logic il, input logic o12, input logic rr,
                                     input logic rl);
    logic bz, ft;
    bz = (st != 3'd0) && (st != 3'd7);
    ft = (st == 3'd7);
    return {st, pl, pi, il, o12, o12, rr, rl, bz, ft};
  endfunction

  function automatic logic [11:0] observed();
    return {state, pc_load, pc_inc, ins_load, op1_load, op2_load, ram_rd, reg_load, busy, fault};
  endfunction

  // Pop one expected vector per cycle and compare
  task automatic drain(input string tag, input logic en_after_fetch);
    logic [11:0] e;
    bit first = 1'b1;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      if (first) begin en = en_after_fetch; first = 1'b0; end
      e = exp_q.pop_front();
      if (pc_inc) pc_inc_seen++;
      chk({tag, "_vec"}, 32'(observed()), 32'(e));
      chk({tag, "_ret"}, 32'(retired), 32'(exp_ret));
      if (e[11:9] == 3'd6) exp_ret = exp_ret + 1'b1;
    end
  endtask

  // Issue one instruction from IDLE or from a WB with en still high
  task automatic run_instr(input string tag, input logic [1:0] b, input logic [1:0] m,
                           input logic [1:0] ot, input logic [3:0] op, input logic fe,
                           input logic en_end);
    logic jmp, pl, rl;
    ins_byte = b; ins_mode = m; ins_ot = ot; ins_opcode = op; flag_eq = fe;
    en = 1'b1;
    jmp = 1'b0;
    pl  = 1'b0;
`ifdef JUMP_EN
    if (ot == 2'b00 && b == 2'b10 && op == 4'b1110) begin jmp = 1'b1; pl = 1'b1; end
    if (ot == 2'b00 && b == 2'b10 && op == 4'b1101) begin jmp = 1'b1; pl = fe;   end
`endif
    rl = !(ot == 2'b01 && op == CMP) && !jmp;
    pc_inc_seen = 0;
    exp_q.push_back(mk(3'd1, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(3'd2, 0, 1, 1, 0, 0, 0));
    if (b == 2'b10) exp_q.push_back(mk(3'd3, 0, 1, 0, 0, (m == 2'b10), 0));
    exp_q.push_back(mk(3'd4, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < int'(EXEC_N); i++) exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(3'd6, pl, 0, 0, 0, 0, rl));
    if (!en_end) exp_q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0));
    drain(tag, en_end);
    chk({tag, "_pcinc_n"}, 32'(pc_inc_seen), (b == 2'b10) ? 32'd2 : 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; flag_eq = 1'b0;
    ins_byte = 2'b01; ins_mode = 2'b00; ins_ot = 2'b00; ins_opcode = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec", 32'(observed()), 32'd0);
    chk("rst_ret", 32'(retired), 32'd0);
    rst_n = 1'b1;

    run_instr("t1_arith", 2'b01, 2'b00, 2'b01, 4'b0001, 1'b0, 1'b0);
    run_instr("t2_direct", 2'b10, 2'b10, 2'b00, 4'b0011, 1'b0, 1'b0);
    run_instr("t2_imm2w", 2'b10, 2'b01, 2'b10, 4'b0101, 1'b0, 1'b0);
    run_instr("t4_enoff", 2'b01, 2'b00, 2'b10, 4'b0110, 1'b0, 1'b0);
    run_instr("t5_cmp", 2'b01, 2'b00, 2'b01, CMP, 1'b0, 1'b0);
    run_instr("byte11", 2'b11, 2'b10, 2'b00, 4'b0010, 1'b0, 1'b1);
    run_instr("jmp_op", 2'b10, 2'b00, 2'b00, 4'b1110, 1'b0, 1'b1);
    run_instr("jeq_f0", 2'b10, 2'b00, 2'b00, 4'b1101, 1'b0, 1'b1);
    run_instr("jeq_f1", 2'b10, 2'b00, 2'b00, 4'b1101, 1'b1, 1'b0);

    // Back-to-back random legal instructions; enough to wrap the 4-bit counter
    for (int k = 0; k < 20; k++) begin
      run_instr("rand", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), (k != 19));
    end

    // Illegal operation type: sticky FAULT, en ignored
    ins_byte = 2'b01; ins_mode = 2'b00; ins_ot = 2'b11; ins_opcode = 4'h3;
    en = 1'b1;
    exp_q.push_back(mk(3'd1, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(3'd2, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 20; i++) exp_q.push_back(mk(3'd7, 0, 0, 0, 0, 0, 0));
    begin
      logic [11:0] e;
      int n = 0;
      while (exp_q.size() > 0) begin
        @(posedge clk); #1;
        en = n[0];
        n++;
        e = exp_q.pop_front();
        chk("t3_fault_vec", 32'(observed()), 32'(e));
        chk("t3_fault_ret", 32'(retired), 32'(exp_ret));
      end
    end

    rst_n = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    chk("t3_rst_vec", 32'(observed()), 32'd0);
    chk("t3_rst_ret", 32'(retired), 32'd0);
    rst_n = 1'b1;
    exp_ret = '0;

    // Reset mid-instruction abandons it without retiring
    ins_ot = 2'b01; ins_opcode = 4'b0001; en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    chk("midrst_vec", 32'(observed()), 32'd0);
    chk("midrst_ret", 32'(retired), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_hold", 32'(observed()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
